// File: rtl/poly1305_seq_pkg.sv
// poly1305_seq_pkg: shared definitions for the Poly1305 message sequencer.
//   seq_state_t  - sequencer FSM states
//   BLOCK_BYTES  - bytes per Poly1305 block
//   WORD_BYTES   - bytes per input stream word
//   PAD_BYTE     - pad byte appended after the last byte of a short block
package poly1305_seq_pkg;

  localparam int         BLOCK_BYTES = 16;
  localparam int         WORD_BYTES  = 4;
  localparam logic [7:0] PAD_BYTE    = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_WAIT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/poly1305_blk_pack.sv
// poly1305_blk_pack: packs 32-bit little-endian words into a 128-bit block.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   clear          - empty the buffer and rewind the word index
//   write          - store 'word' at the current word index, advance index
//   word           - incoming word, first byte in [7:0]
//   nbytes, last   - valid bytes of a final word (0 or >4 mean 4)
//   block          - buffer merged with the current word, padded when short
//   full_flag      - merged block holds 16 message bytes
//   n              - message bytes in the merged block (4*idx + valid bytes)
module poly1305_blk_pack
  import poly1305_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         write,
  input  logic [31:0]  word,
  input  logic [2:0]   nbytes,
  input  logic         last,
  output logic [127:0] block,
  output logic         full_flag,
  output logic [4:0]   n
);

  logic [127:0] buf_q;
  logic [1:0]   idx_q;
  logic [2:0]   eff_nbytes;
  logic [31:0]  word_masked;

  // The block view already contains the word being offered this cycle, so
  // the sequencer can capture a finished block on the same edge that accepts
  // the final word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    eff_nbytes  = 3'd4;
    word_masked = '0;
    if (last && nbytes >= 3'd1 && nbytes <= 3'd4) begin
      eff_nbytes = nbytes;
    end
    // Bytes past the valid count are dropped so the pad lands on zeros.
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b < int'(eff_nbytes)) begin
        word_masked[8*b +: 8] = word[8*b +: 8];
      end
    end
    n         = {1'b0, idx_q, 2'b00} + {2'b00, eff_nbytes};
    full_flag = (n == 5'(BLOCK_BYTES));
    block     = buf_q;
    block[{idx_q, 5'b00000} +: 32] = word_masked;
    if (!full_flag) begin
      block[{n[3:0], 3'b000} +: 8] = PAD_BYTE;
    end
  end

  // NOTE: the buffer is reset along with the index; after an aborted message
  // stale bytes would otherwise sit above the pad position of the next block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (write) begin
      buf_q[{idx_q, 5'b00000} +: 32] <= word_masked;
      idx_q                          <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/poly1305_seq.sv
// poly1305_seq: message sequencer driving the poly1305 block core.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   start, key_r, key_s        - begin a message, one-time key (IDLE only)
//   in_data/in_nbytes/in_last  - 32-bit message word stream
//   in_valid, in_ready         - word handshake
//   core_r/core_s/core_m       - core operands, stable while the core works
//   core_fb, core_first        - full-block and first-block qualifiers
//   core_ld                    - one-cycle block load strobe
//   core_p, core_rdy           - core tag and idle/result-valid
//   tag, tag_valid             - final tag and its one-cycle update pulse
//   busy                       - message in progress
module poly1305_seq
  import poly1305_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_r,
  input  logic [127:0] key_s,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] core_r,
  output logic [127:0] core_s,
  output logic [127:0] core_m,
  output logic         core_fb,
  output logic         core_first,
  output logic         core_ld,
  input  logic [127:0] core_p,
  input  logic         core_rdy,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy
);

  seq_state_t   state;
  logic         first_flag;
  logic         last_flag;
  logic         accept;
  logic         blk_end;
  logic         pack_clear;
  logic [127:0] pack_block;
  logic         pack_full;
  logic [4:0]   pack_n;

  assign accept     = (state == S_FILL) && in_valid && in_ready;
  assign blk_end    = in_last || (pack_n == 5'(BLOCK_BYTES));
  assign pack_clear = ((state == S_IDLE) && start) ||
                      ((state == S_WAIT) && core_rdy && !last_flag);

  poly1305_blk_pack u_pack (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .write     (accept),
    .word      (in_data),
    .nbytes    (in_nbytes),
    .last      (in_last),
    .block     (pack_block),
    .full_flag (pack_full),
    .n         (pack_n)
  );

  // All outputs are registered and change only on state transitions.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      first_flag <= 1'b0;
      last_flag  <= 1'b0;
      in_ready   <= 1'b0;
      core_r     <= '0;
      core_s     <= '0;
      core_m     <= '0;
      core_fb    <= 1'b0;
      core_first <= 1'b0;
      core_ld    <= 1'b0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            core_r     <= key_r;
            core_s     <= key_s;
            first_flag <= 1'b1;
            last_flag  <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept && blk_end) begin
            core_m     <= pack_block;
            core_fb    <= pack_full;
            core_first <= first_flag;
            last_flag  <= in_last;
            in_ready   <= 1'b0;
            core_ld    <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          core_ld    <= 1'b0;
          first_flag <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // The core drops rdy on the edge that samples ld, so rdy seen here
          // always belongs to the block just loaded.
          if (core_rdy) begin
            if (last_flag) begin
              tag       <= core_p;
              tag_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FILL;
            end
          end
        end
        S_DONE: begin
          tag_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly1305_seq.sv
// tb_poly1305_seq: self-checking bench for poly1305_seq with a behavioural
// Poly1305 core (configurable latency) and a block/tag scoreboard.
module tb_poly1305_seq;

  typedef struct packed {
    logic [127:0] m;
    logic         fb;
    logic         first;
  } blk_t;

  localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [260:0] P_MOD   = (261'd1 << 130) - 261'd5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_r = '0;
  logic [127:0] key_s = '0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_nbytes = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] core_r, core_s, core_m, core_p, tag;
  logic         core_fb, core_first, core_ld, core_rdy, tag_valid, busy;

  int total = 0;
  int bad   = 0;

  blk_t         blk_q[$];
  logic [127:0] tag_q[$];

  int           core_lat = 1;
  int           ld_count = 0;
  int           tv_count = 0;
  int           bp_cycles = 0;
  logic [7:0]   ld_first_bits = '0;
  logic [7:0]   ld_fb_bits = '0;
  logic [127:0] last_m = '0;
  logic [127:0] last_tag = '0;
  logic [127:0] wait_m = '0;
  logic         prev_tv = 1'b0;

  always #5 clk = ~clk;

  poly1305_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_r      (key_r),
    .key_s      (key_s),
    .in_data    (in_data),
    .in_nbytes  (in_nbytes),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .core_r     (core_r),
    .core_s     (core_s),
    .core_m     (core_m),
    .core_fb    (core_fb),
    .core_first (core_first),
    .core_ld    (core_ld),
    .core_p     (core_p),
    .core_rdy   (core_rdy),
    .tag        (tag),
    .tag_valid  (tag_valid),
    .busy       (busy)
  );

  // One Poly1305 block step: acc = ((acc + block) * clamp(r)) mod 2^130-5.
  function automatic logic [129:0] poly_step(input logic [129:0] acc,
                                             input logic [127:0] m,
                                             input logic fb,
                                             input logic [127:0] r);
    logic [260:0] x;
    x = ({131'd0, acc} + {132'd0, fb, m}) * {133'd0, r & R_CLAMP};
    repeat (3) x = {131'd0, x[129:0]} + (x >> 130) * 261'd5;
    while (x >= P_MOD) x = x - P_MOD;
    return x[129:0];
  endfunction

  // Behavioural core: rdy falls on the ld edge, rises core_lat cycles later.
  logic [129:0] core_acc;
  int           core_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_acc <= '0;
      core_cnt <= 0;
      core_rdy <= 1'b1;
      core_p   <= '0;
    end else if (core_ld) begin
      core_acc <= poly_step(core_first ? 130'd0 : core_acc, core_m, core_fb, core_r);
      core_cnt <= core_lat;
      core_rdy <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_rdy <= 1'b1;
        core_p   <= core_acc[127:0] + core_s;
      end
    end
  end

  // Output monitor: block loads and tags are popped from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_ld) begin
        blk_t exp_b;
        ld_count++;
        ld_first_bits = {ld_first_bits[6:0], core_first};
        ld_fb_bits    = {ld_fb_bits[6:0], core_fb};
        last_m = core_m;
        wait_m = core_m;
        total++;
        if (blk_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ld: m=%h fb=%0b first=%0b, required no load", core_m, core_fb, core_first);
        end else begin
          exp_b = blk_q.pop_front();
          if ({core_m, core_fb, core_first} !== exp_b) begin
            bad++;
            $display("FAIL block: m=%h fb=%0b first=%0b, required m=%h fb=%0b first=%0b",
                     core_m, core_fb, core_first, exp_b.m, exp_b.fb, exp_b.first);
          end
        end
      end
      if (busy && !core_rdy) begin
        if (in_valid) bp_cycles++;
        total++;
        if (in_ready !== 1'b0 || core_m !== wait_m) begin
          bad++;
          $display("FAIL wait_hold: in_ready=%0b m=%h, required in_ready=0 m=%h", in_ready, core_m, wait_m);
        end
      end
      if (tag_valid) begin
        tv_count++;
        last_tag = tag;
        total++;
        if (prev_tv) begin
          bad++;
          $display("FAIL tag_valid_width: tag_valid=1 on consecutive cycles, required single pulse");
        end else if (tag_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tag: tag=%h, required no tag_valid", tag);
        end else begin
          logic [127:0] exp_t;
          exp_t = tag_q.pop_front();
          if (tag !== exp_t) begin
            bad++;
            $display("FAIL tag: got %h, required %h", tag, exp_t);
          end
        end
      end
      prev_tv = tag_valid;
    end else begin
      prev_tv = 1'b0;
    end
  end

  // Scoreboard model: expected blocks and tag of a whole message.
  task automatic push_expected(input logic [7:0] msg[$], input logic [127:0] r,
                               input logic [127:0] s);
    logic [129:0] acc;
    blk_t         b;
    int           cnt;
    acc = '0;
    for (int i = 0; i < msg.size(); i += 16) begin
      cnt = (msg.size() - i > 16) ? 16 : msg.size() - i;
      b.m = '0;
      for (int j = 0; j < cnt; j++) b.m[8*j +: 8] = msg[i+j];
      if (cnt < 16) b.m[8*cnt +: 8] = 8'h01;
      b.fb    = (cnt == 16);
      b.first = (i == 0);
      blk_q.push_back(b);
      acc = poly_step(b.first ? 130'd0 : acc, b.m, b.fb, r);
    end
    tag_q.push_back(acc[127:0] + s);
  endtask

  task automatic start_msg(input logic [127:0] r, input logic [127:0] s);
    @(negedge clk);
    key_r = r;
    key_s = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: in_ready=%0b busy=%0b, required 1 1", in_ready, busy);
    end
  endtask

  // Drives the words of msg; garbage in unused bytes and in_nbytes of
  // non-final words. At word start_at a stray start with a new key is raised.
  task automatic send_words(input logic [7:0] msg[$], input int start_at);
    int          nw, rem, nb, guard, alt;
    logic [31:0] d;
    nw = (msg.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      rem = msg.size() - 4*w;
      nb  = (rem > 4) ? 4 : rem;
      d   = $urandom();
      for (int b = 0; b < nb; b++) d[8*b +: 8] = msg[4*w+b];
      in_data = d;
      in_last = (w == nw - 1);
      if (!in_last) begin
        in_nbytes = 3'($urandom_range(0, 7));
      end else if (nb == 4) begin
        alt = $urandom_range(0, 4);
        in_nbytes = (alt == 0) ? 3'd0 : 3'(alt + 3);
      end else begin
        in_nbytes = 3'(nb);
      end
      if (w == start_at) begin
        start = 1'b1;
        key_r = ~key_r;
        key_s = ~key_s;
      end
      in_valid = 1'b1;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready=%0b, required 1 within 300 cycles", in_ready);
      end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_tag(input bit start_in_done);
    int guard;
    guard = 0;
    while (tag_valid !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 400) begin
      bad++;
      $display("FAIL tag_timeout: tag_valid=%0b, required 1 within 400 cycles", tag_valid);
    end
    if (start_in_done) begin
      start = 1'b1;
      key_r = ~key_r;
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_done: busy=%0b, required 0", busy);
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input logic [127:0] r,
                         input logic [127:0] s);
    push_expected(msg, r, s);
    start_msg(r, s);
    send_words(msg, -1);
    wait_tag(1'b0);
  endtask

  task automatic check_idle_zero(input string name);
    total++;
    if ({in_ready, core_ld, core_fb, core_first, tag_valid, busy, tag, core_r, core_s, core_m} !== '0) begin
      bad++;
      $display("FAIL %s: in_ready=%0b ld=%0b fb=%0b first=%0b tv=%0b busy=%0b tag=%h r=%h s=%h m=%h, required all 0",
               name, in_ready, core_ld, core_fb, core_first, tag_valid, busy, tag, core_r, core_s, core_m);
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_zero("reset_outputs");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_full_block();
    logic [7:0] msg[$];
    int ld0;
    for (int i = 0; i < 16; i++) msg.push_back(8'(i));
    core_lat = 1;
    ld0 = ld_count;
    run_msg(msg, 128'h0123456789abcdef0011223344556677, 128'h00000000000000000000000000000001);
    total++;
    if (ld_count - ld0 != 1 || last_m !== 128'h0f0e0d0c0b0a09080706050403020100 ||
        ld_first_bits[0] !== 1'b1 || ld_fb_bits[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_block: loads=%0d m=%h first=%0b fb=%0b, required 1 0f0e0d0c0b0a09080706050403020100 1 1",
               ld_count - ld0, last_m, ld_first_bits[0], ld_fb_bits[0]);
    end
  endtask

  task automatic test_short_block();
    logic [7:0] msg[$];
    for (int i = 0; i < 5; i++) msg.push_back(8'(i));
    core_lat = 2;
    run_msg(msg, 128'hffeeddccbbaa99887766554433221100, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f);
    total++;
    if (last_m !== 128'h010403020100 || ld_fb_bits[0] !== 1'b0 || ld_first_bits[0] !== 1'b1) begin
      bad++;
      $display("FAIL short_block: m=%h fb=%0b first=%0b, required 010403020100 0 1",
               last_m, ld_fb_bits[0], ld_first_bits[0]);
    end
  endtask

  task automatic test_rfc_vector();
    string      text;
    logic [7:0] msg[$];
    int         ld0, tv0;
    text = "Cryptographic Forum Research Group";
    for (int i = 0; i < text.len(); i++) msg.push_back(text[i]);
    core_lat = 3;
    ld0 = ld_count;
    tv0 = tv_count;
    run_msg(msg, 128'ha806d542fe52447f336d555778bed685, 128'h1bf54941aff6bf4afdb20dfb8a800301);
    total++;
    if (ld_count - ld0 != 3 || ld_first_bits[2:0] !== 3'b100 || ld_fb_bits[2:0] !== 3'b110) begin
      bad++;
      $display("FAIL rfc_loads: loads=%0d first=%b fb=%b, required 3 100 110",
               ld_count - ld0, ld_first_bits[2:0], ld_fb_bits[2:0]);
    end
    total++;
    if (tv_count - tv0 != 1 || last_tag !== 128'ha927010caf8b2bc2c6365130c11d06a8) begin
      bad++;
      $display("FAIL rfc_tag: pulses=%0d tag=%h, required 1 a927010caf8b2bc2c6365130c11d06a8",
               tv_count - tv0, last_tag);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] msg[$];
    int ld0;
    for (int i = 0; i < 24; i++) msg.push_back(8'($urandom()));
    core_lat = 7;
    ld0 = ld_count;
    bp_cycles = 0;
    run_msg(msg, 128'h1111222233334444555566667777aaaa, 128'h9999888877776666555544443333bbbb);
    total++;
    if (ld_count - ld0 != 2 || bp_cycles != 7) begin
      bad++;
      $display("FAIL backpressure: loads=%0d stalled_cycles=%0d, required 2 7", ld_count - ld0, bp_cycles);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0]   msg[$];
    logic [127:0] r, s;
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom()));
    r = 128'hdeadbeef0badf00dcafef00d12345678;
    s = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    core_lat = 2;
    push_expected(msg, r, s);
    start_msg(r, s);
    send_words(msg, 2);
    wait_tag(1'b1);
    total++;
    if (core_r !== r || core_s !== s || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored: r=%h s=%h in_ready=%0b, required r=%h s=%h in_ready=0",
               core_r, core_s, in_ready, r, s);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] msg[$];
    int tv0;
    for (int i = 0; i < 16; i++) msg.push_back(8'(8'h40 + i));
    core_lat = 7;
    push_expected(msg, 128'h0a0b0c0d0e0f00010203040506070809, 128'h1);
    start_msg(128'h0a0b0c0d0e0f00010203040506070809, 128'h1);
    send_words(msg, -1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_idle_zero("async_reset_in_wait");
    blk_q.delete();
    tag_q.delete();
    tv0 = tv_count;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (tv_count != tv0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: tag_valid_pulses=%0d busy=%0b, required 0 0", tv_count - tv0, busy);
    end
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'(i));
    core_lat = 1;
    run_msg(msg, 128'h77, 128'h88);
    total++;
    if (last_m !== 128'h010403020100) begin
      bad++;
      $display("FAIL restart_after_reset: m=%h, required 010403020100", last_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]   msg[$];
    logic [127:0] r, s;
    for (int k = 0; k < 8; k++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) msg.push_back(8'($urandom()));
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      core_lat = $urandom_range(1, 5);
      run_msg(msg, r, s);
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_short_block();
    test_rfc_vector();
    test_backpressure();
    test_start_ignored();
    test_reset_in_wait();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (blk_q.size() != 0 || tag_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: blocks_left=%0d tags_left=%0d, required 0 0", blk_q.size(), tag_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
